// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 pooling stream: mode encoding and the
// horizontal pair combine used on both rows of a window.
package pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    // Widest pixel the pair function handles; callers zero-extend and truncate.
    localparam int PAIR_MAX_W = 32;

    // Max mode keeps the larger pixel, avg mode keeps the full-width sum.
    function automatic logic [PAIR_MAX_W:0] pair_combine(
        input pool_mode_e            mode,
        input logic [PAIR_MAX_W-1:0] a,
        input logic [PAIR_MAX_W-1:0] b
    );
        logic [PAIR_MAX_W:0] res;
        if (mode == POOL_AVG) begin
            res = {1'b0, a} + {1'b0, b};
        end else begin
            res = (a > b) ? {1'b0, a} : {1'b0, b};
        end
        return res;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding the top-row pair results of each window column.
// One write port, asynchronous read port, contents are not reset.
module pool_line_buf #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 9,
    parameter int AW    = 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pool2d_stream.sv
// Streaming 2x2 / stride-2 max or average pooling over a raster-order frame,
// with a one-deep output register and valid/ready flow control on both sides.
module pool2d_stream
    import pool_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_avg,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int DEPTH = IMG_W / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] held_q, held_d;
    pool_mode_e        mode_q, mode_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;

    logic              accept;
    logic              last_col, last_row;
    logic              lb_we, win_done;
    logic [AW-1:0]     lb_addr;
    logic [DATA_W:0]   pair, lb_rd;
    logic [DATA_W-1:0] win_val;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));
    assign lb_addr  = AW'(col_q >> 1);
    assign lb_we    = accept && !row_q[0] && col_q[0];
    assign win_done = accept &&  row_q[0] && col_q[0];

    assign pair = (DATA_W+1)'(pair_combine(mode_q, PAIR_MAX_W'(held_q), PAIR_MAX_W'(in_data)));

    // Vertical combine of the bottom pair with the stored top pair.
    assign win_val = (mode_q == POOL_AVG)
                   ? DATA_W'(({1'b0, pair} + {1'b0, lb_rd}) >> 2)
                   : DATA_W'((pair > lb_rd) ? pair : lb_rd);

    pool_line_buf #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + 1),
        .AW    (AW)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (lb_we),
        .wr_addr (lb_addr),
        .wr_data (pair),
        .rd_addr (lb_addr),
        .rd_data (lb_rd)
    );

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        held_d      = held_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (accept) begin
            col_d = last_col ? '0 : col_q + 1'b1;
            if (last_col) begin
                row_d = last_row ? '0 : row_q + 1'b1;
            end
            if (!col_q[0]) begin
                held_d = in_data;
            end
            if (col_q == '0 && row_q == '0) begin
                mode_d = pool_mode_e'(mode_avg);
            end
        end

        // A window completion is only possible when in_ready is high, so any
        // pending output is being consumed on the same edge.
        if (win_done) begin
            out_valid_d = 1'b1;
            out_data_d  = win_val;
            out_last_d  = last_row && last_col;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            held_q      <= '0;
            mode_q      <= POOL_MAX;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            held_q      <= held_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_pool2d_stream.sv
// Self-checking bench for pool2d_stream: table-driven frames plus hand-written
// backpressure, mode-switch, and mid-frame reset sequences, with a scoreboard.
module tb_pool2d_stream;

    typedef logic [0:15][7:0] frame_t;
    typedef logic [0:3][7:0]  out4_t;

    typedef struct packed {
        logic   mode;
        frame_t px;
        out4_t  exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode_avg;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] sb_q[$];

    pool2d_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_avg  (mode_avg),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Reference pooling over a 4x4 frame.
    function automatic out4_t pool_model(input frame_t f, input logic m);
        out4_t res;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                int a, b, d, e, mx, sum;
                a   = f[(2*r)*4 + 2*c];
                b   = f[(2*r)*4 + 2*c + 1];
                d   = f[(2*r+1)*4 + 2*c];
                e   = f[(2*r+1)*4 + 2*c + 1];
                mx  = a;
                if (b > mx) mx = b;
                if (d > mx) mx = d;
                if (e > mx) mx = e;
                sum = a + b + d + e;
                res[r*2 + c] = m ? 8'(sum / 4) : 8'(mx);
            end
        end
        return res;
    endfunction

    task automatic push_expect(input out4_t e);
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back({(k == 3), e[k]});
        end
    endtask

    task automatic send_px(input logic [7:0] d, input logic m);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        mode_avg = m;
        @(negedge clk);
        while (!in_ready) begin
            waited++;
            if (waited > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL in_accept_timeout: in_ready=%0b required 1 within 200 cycles", in_ready);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Pixels from index tog onward carry mode m2; the frame uses m at (0,0).
    task automatic send_frame(input frame_t f, input logic m, input int tog, input logic m2);
        for (int i = 0; i < 16; i++) begin
            send_px(f[i], (i >= tog) ? m2 : m);
        end
    endtask

    task automatic drain(input string tag);
        int waited;
        waited = 0;
        while (sb_q.size() != 0 && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        #1;
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d outputs still pending, required 0", tag, sb_q.size());
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0b required %0b", name, act, req);
        end else begin
            $display("ok   %s = %0b", name, act);
        end
    endtask

    // Output monitor: scoreboard compare on handshake, stability during stalls.
    logic       stall_prev = 1'b0;
    logic [7:0] held_data;
    logic       held_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
                    n_err++;
                    $display("FAIL hold_stable: valid=%0b data=%0d last=%0b required valid=1 data=%0d last=%0b",
                             out_valid, out_data, out_last, held_data, held_last);
                end
            end
            if (out_valid && !out_ready) begin
                n_vec++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL in_ready_pending: got %0b required 0", in_ready);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: data=%0d last=%0b, required no output", out_data, out_last);
                end else begin
                    logic [8:0] e;
                    e = sb_q.pop_front();
                    if (out_data !== e[7:0] || out_last !== e[8]) begin
                        n_err++;
                        $display("FAIL out_pixel: data=%0d last=%0b required data=%0d last=%0b",
                                 out_data, out_last, e[7:0], e[8]);
                    end else begin
                        $display("out  data=%0d last=%0b", out_data, out_last);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            held_last  = out_last;
        end
    end

    vec_t   tbl[4];
    frame_t base;
    frame_t f2;

    initial begin
        base = '{8'd2, 8'd0, 8'd2, 8'd1,
                 8'd6, 8'd3, 8'd8, 8'd7,
                 8'd3, 8'd4, 8'd0, 8'd1,
                 8'd2, 8'd1, 8'd5, 8'd2};
        tbl[0] = '{mode: 1'b0, px: base,          exp: '{8'd6, 8'd8, 8'd4, 8'd5}};
        tbl[1] = '{mode: 1'b1, px: base,          exp: '{8'd2, 8'd4, 8'd2, 8'd2}};
        tbl[2] = '{mode: 1'b1, px: {16{8'hFF}},   exp: '{8'd255, 8'd255, 8'd255, 8'd255}};
        tbl[3] = '{mode: 1'b0, px: {16{8'hFF}},   exp: '{8'd255, 8'd255, 8'd255, 8'd255}};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        mode_avg  = 1'b0;
        out_ready = 1'b1;
        #2;
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_out_last",  out_last,  1'b0);
        check_bit("rst_in_ready",  in_ready,  1'b1);
        n_vec++;
        if (out_data !== 8'd0) begin
            n_err++;
            $display("FAIL rst_out_data: got %0d required 0", out_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table frames, sent back to back.
        for (int t = 0; t < 4; t++) begin
            push_expect(tbl[t].exp);
            send_frame(tbl[t].px, tbl[t].mode, 16, tbl[t].mode);
        end
        drain("table");

        // Output stalled for 10 cycles once the first result appears.
        out_ready = 1'b0;
        push_expect('{8'd6, 8'd8, 8'd4, 8'd5});
        fork
            send_frame(base, 1'b0, 16, 1'b0);
            begin
                int w;
                w = 0;
                while (!out_valid && w < 100) begin
                    @(posedge clk);
                    w++;
                end
                repeat (10) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("stall");

        // Mode toggled mid-frame: frame 1 keeps max, frame 2 uses avg.
        for (int i = 0; i < 16; i++) f2[i] = 8'($urandom_range(0, 255));
        push_expect(pool_model(base, 1'b0));
        push_expect(pool_model(f2, 1'b1));
        send_frame(base, 1'b0, 6, 1'b1);
        send_frame(f2, 1'b1, 16, 1'b1);
        drain("mode_switch");

        // Random frames with random mode and backpressure.
        for (int k = 0; k < 3; k++) begin
            logic m;
            m = 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) f2[i] = 8'($urandom_range(0, 255));
            push_expect(pool_model(f2, m));
            fork
                send_frame(f2, m, 16, m);
                begin
                    for (int c = 0; c < 40; c++) begin
                        @(posedge clk);
                        #1;
                        out_ready = 1'($urandom_range(0, 1));
                    end
                    out_ready = 1'b1;
                end
            join
            drain("random");
        end

        // Mid-frame reset with a result pending, then a clean frame.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_px(base[i], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("async_rst_out_valid", out_valid, 1'b0);
        check_bit("async_rst_out_last",  out_last,  1'b0);
        check_bit("async_rst_in_ready",  in_ready,  1'b1);
        n_vec++;
        if (out_data !== 8'd0) begin
            n_err++;
            $display("FAIL async_rst_out_data: got %0d required 0", out_data);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        push_expect('{8'd6, 8'd8, 8'd4, 8'd5});
        send_frame(base, 1'b0, 16, 1'b0);
        drain("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pool2d_stream.md
POOL2D_STREAM -- requirements
Module: pool2d_stream

Interface
REQ-001 Parameter DATA_W, 8, unsigned pixel width in bits.
REQ-002 Parameter IMG_W, 4, pixels per row; even, >=2.
REQ-003 Parameter IMG_H, 4, rows per frame; even, >=2.
REQ-004 Port clk  input  1  single clock; all state on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port mode_avg  input  1  0 = 2x2 max pooling, 1 = 2x2 average pooling.
REQ-007 Port in_valid  input  1  in_data is valid this cycle.
REQ-008 Port in_ready  output  1  block accepts in_data this cycle.
REQ-009 Port in_data  input  DATA_W  pixel; raster order, row-major, top-left first.
REQ-010 Port out_valid  output  1  out_data is valid.
REQ-011 Port out_ready  input  1  downstream accepts out_data.
REQ-012 Port out_data  output  DATA_W  pooled pixel; raster order over the (IMG_W/2)x(IMG_H/2) output.
REQ-013 Port out_last  output  1  high with the final pooled pixel of a frame.

Function
REQ-014 Transfer on either port SHALL occur only on a cycle where valid and ready are both high.
REQ-015 Window 2x2, stride 2, no padding; output (r,c) covers input rows 2r..2r+1, cols 2c..2c+1.
REQ-016 Counters col (0..IMG_W-1) and row (0..IMG_H-1) SHALL advance only on accepted input; col wraps to 0 and increments row; row wraps to 0 after the last pixel of a frame.
REQ-017 Even row, odd col: pair result (max, or DATA_W+1-bit sum, of the pixel held from the even col and the current pixel) SHALL be written to line-buffer entry col/2.
REQ-018 Odd row, odd col: current pair result SHALL be combined with line-buffer entry col/2 and loaded into the output register.
REQ-019 Max mode: out_data = maximum of the 4 window pixels, unsigned compare.
REQ-020 Avg mode: 4-pixel sum in DATA_W+2 bits, out_data = sum >> 2 (floor), no saturation needed.
REQ-021 mode_avg SHALL be sampled on acceptance of pixel (0,0) and held for the whole frame; changes mid-frame have no effect until the next frame.
REQ-022 Latency: out_valid SHALL rise the cycle after the accepting edge of the window's last pixel.
REQ-023 out_valid/out_data/out_last SHALL hold stable until accepted by out_ready.
REQ-024 in_ready = !out_valid || out_ready (combinational); a pending output plus a new window completion SHALL never lose data.
REQ-025 out_last SHALL be high exactly for output (IMG_H/2-1, IMG_W/2-1) and low otherwise.
REQ-026 Back-to-back frames SHALL be accepted without idle cycles; counters and line buffer need no clearing between frames.
REQ-027 in_valid low SHALL freeze all counters, the held pixel and the line buffer.

Reset
REQ-028 On rst_n low: out_valid=0, out_data=0, out_last=0, col=0, row=0, latched mode=0 (max), held pixel=0; in_ready follows REQ-024 (thus 1).
REQ-029 Reset mid-frame SHALL discard the partial frame; the first pixel accepted after release is pixel (0,0).
REQ-030 Line-buffer contents need not be reset (always written before read).

Structure
REQ-031 Package pool_pkg SHALL hold the mode encoding constants (POOL_MAX=0, POOL_AVG=1) and the pair-combine function shared by both rows.
REQ-032 Sub-module pool_line_buf: IMG_W/2 entries x (DATA_W+1) bits, one write and one read port, asynchronous read, no reset.
REQ-033 Counters, held pixel, mode latch and output register SHALL live in pool2d_stream.

Verification
REQ-034 Max, 4x4, rows {2,0,2,1},{6,3,8,7},{3,4,0,1},{2,1,5,2}, out_ready=1 -> out 6,8,4,5; out_last only on 5.
REQ-035 Same frame, mode_avg=1 -> out 2,4,2,2 (sums 11,18,10,8 floored /4).
REQ-036 DATA_W=8, all pixels 255, avg -> every output 255 (no overflow); max -> 255.
REQ-037 out_ready low 10 cycles after first output -> out_data 6 held stable, in_ready low while pending, no loss; full sequence 6,8,4,5 after release.
REQ-038 mode_avg toggled at pixel (1,2), two back-to-back frames -> frame 1 uses mode at its (0,0), frame 2 uses new mode; counters wrap without gap.
REQ-039 rst_n pulsed low after 6 pixels -> outputs 0 immediately (async); next full frame yields 6,8,4,5 correctly.
